// File: rtl/cpu_clock_ctrl.sv
// CPU step-enable controller: turns divider rises or a debounced step button
// into single-cycle cpu_enable pulses, with run/step/halt modes and a step counter.
module cpu_clock_ctrl #(
  parameter int unsigned DEBOUNCE = 500000,
  parameter int unsigned DB_WIDTH = 20
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        div_clock,
  input  logic        step_button,
  input  logic        run_switch,
  input  logic        halt,
  output logic        cpu_enable,
  output logic [1:0]  state_led,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE - 1);

  logic                btn_s1, btn_s2;
  logic                run_s1, run_s2;
  logic                div_d;
  logic [DB_WIDTH-1:0] db_count;
  logic                btn_stable, btn_stable_d;
  logic                run_sync, div_rise, step_req;
  logic [15:0]         step_cnt;
  state_t              state, state_next;
  logic                pulse_next;

  // Two-flop synchronizers for the asynchronous operator inputs; div_clock is
  // already in this domain and only needs one delay stage for edge detection.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      div_d  <= 1'b0;
    end else begin
      btn_s1 <= step_button;
      btn_s2 <= btn_s1;
      run_s1 <= run_switch;
      run_s2 <= run_s1;
      div_d  <= div_clock;
    end
  end

  assign run_sync = run_s2;
  assign div_rise = div_clock & ~div_d;

  // Any return to the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      db_count     <= '0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
    end else begin
      btn_stable_d <= btn_stable;
      if (btn_s2 != btn_stable) begin
        if (db_count == DB_LAST) begin
          btn_stable <= btn_s2;
          db_count   <= '0;
        end else begin
          db_count <= db_count + 1'b1;
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  assign step_req = btn_stable & ~btn_stable_d;

  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    case (state)
      ST_STOP: begin
        if (halt)          state_next = ST_HALTED;
        else if (run_sync) state_next = ST_RUN;
        else if (step_req) pulse_next = 1'b1;
      end
      ST_RUN: begin
        if (halt)           state_next = ST_HALTED;
        else if (!run_sync) state_next = ST_STOP;
        else if (div_rise)  pulse_next = 1'b1;
      end
      // Leaving HALTED requires the switch in manual so the CPU cannot race off.
      ST_HALTED: begin
        if (!halt && !run_sync) state_next = ST_STOP;
      end
      default: state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_STOP;
      cpu_enable <= 1'b0;
      step_cnt   <= '0;
    end else begin
      state      <= state_next;
      cpu_enable <= pulse_next;
      if (cpu_enable) step_cnt <= step_cnt + 16'd1;
    end
  end

  assign state_led  = state;
  assign step_count = step_cnt;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed testbench for cpu_clock_ctrl: reset, free-run, single step with
// bounce, halt handling, counter wrap and asynchronous reset of a live pulse.
module tb_cpu_clock_ctrl;

  logic        clock_in;
  logic        reset_n;
  logic        div_clock;
  logic        step_button;
  logic        run_switch;
  logic        halt;
  logic        cpu_enable;
  logic [1:0]  state_led;
  logic [15:0] step_count;

  int compared   = 0;
  int mismatched = 0;
  int pulses;
  int pos;

  cpu_clock_ctrl #(.DEBOUNCE(4), .DB_WIDTH(20)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .div_clock  (div_clock),
    .step_button(step_button),
    .run_switch (run_switch),
    .halt       (halt),
    .cpu_enable (cpu_enable),
    .state_led  (state_led),
    .step_count (step_count)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  initial begin
    reset_n     = 1'b0;
    div_clock   = 1'b0;
    step_button = 1'b0;
    run_switch  = 1'b1;
    halt        = 1'b0;

    // Reset held with div_clock toggling and run requested
    for (int i = 0; i < 6; i++) begin
      div_clock = i[0];
      @(negedge clock_in);
      check_output("reset_enable", {15'd0, cpu_enable}, 16'd0);
      check_output("reset_state", {14'd0, state_led}, 16'd0);
      check_output("reset_count", step_count, 16'd0);
    end
    div_clock = 1'b0;
    reset_n   = 1'b1;
    wait_cycles(2);
    check_output("release_still_stop", {14'd0, state_led}, 16'd0);
    wait_cycles(1);
    check_output("release_run", {14'd0, state_led}, 16'd1);

    // Free-run: div_clock period 10, a pulse seen one negedge after each rise
    for (int i = 0; i < 100; i++) begin
      check_output($sformatf("run_pulse[%0d]", i), {15'd0, cpu_enable},
                   {15'd0, (i % 10) == 1});
      div_clock = ((i % 10) < 5);
      @(negedge clock_in);
    end
    check_output("run_count", step_count, 16'd10);

    // Back to manual step mode
    run_switch = 1'b0;
    wait_cycles(2);
    check_output("stop_pending", {14'd0, state_led}, 16'd1);
    wait_cycles(1);
    check_output("stop_state", {14'd0, state_led}, 16'd0);

    // Clean press: pulse at edge e0+6, seen at the 7th negedge
    step_button = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_in);
      check_output($sformatf("press_pulse[%0d]", k), {15'd0, cpu_enable}, {15'd0, k == 7});
    end
    check_output("press_count", step_count, 16'd11);

    // Release never produces a step
    step_button = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_in);
      if (cpu_enable) pulses++;
    end
    check_output("release_pulses", 16'(pulses), 16'd0);

    // Bounce 1-0-1 at 2-cycle intervals, then stable
    step_button = 1'b1;
    pulses = 0;
    pos = -1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock_in);
      if (cpu_enable) begin
        pulses++;
        pos = k;
      end
      if (k == 2) step_button = 1'b0;
      if (k == 4) step_button = 1'b1;
    end
    check_output("bounce_pulses", 16'(pulses), 16'd1);
    check_output("bounce_position", 16'(pos), 16'd11);
    check_output("bounce_count", step_count, 16'd12);
    step_button = 1'b0;
    wait_cycles(20);

    // Halt from STOP takes effect at the next edge, and resumes to STOP
    halt = 1'b1;
    wait_cycles(1);
    check_output("stop_halt_state", {14'd0, state_led}, 16'd2);
    halt = 1'b0;
    wait_cycles(1);
    check_output("stop_halt_resume", {14'd0, state_led}, 16'd0);

    // Enter RUN, then halt coinciding with a div_clock rise
    run_switch = 1'b1;
    wait_cycles(3);
    check_output("halt_run_state", {14'd0, state_led}, 16'd1);
    halt      = 1'b1;
    div_clock = 1'b1;
    wait_cycles(1);
    check_output("halt_no_pulse", {15'd0, cpu_enable}, 16'd0);
    check_output("halt_state", {14'd0, state_led}, 16'd2);

    // Halt released with run still on: stays HALTED, no pulses on rises
    halt = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      div_clock = k[0];
      @(negedge clock_in);
      if (cpu_enable) pulses++;
    end
    check_output("halted_pulses", 16'(pulses), 16'd0);
    check_output("halted_hold", {14'd0, state_led}, 16'd2);
    div_clock  = 1'b0;
    run_switch = 1'b0;
    wait_cycles(2);
    check_output("halted_pending", {14'd0, state_led}, 16'd2);
    wait_cycles(1);
    check_output("halted_to_stop", {14'd0, state_led}, 16'd0);
    check_output("halt_count", step_count, 16'd12);

    // Preload counter near wrap, then issue pulses in RUN
    force dut.step_cnt = 16'hFFFE;
    @(negedge clock_in);
    release dut.step_cnt;
    @(negedge clock_in);
    check_output("wrap_preload", step_count, 16'hFFFE);
    run_switch = 1'b1;
    wait_cycles(3);
    check_output("wrap_run_state", {14'd0, state_led}, 16'd1);
    div_clock = 1'b1;
    wait_cycles(1);
    check_output("wrap_pulse1", {15'd0, cpu_enable}, 16'd1);
    div_clock = 1'b0;
    wait_cycles(1);
    check_output("wrap_ffff", step_count, 16'hFFFF);
    div_clock = 1'b1;
    wait_cycles(1);
    check_output("wrap_pulse2", {15'd0, cpu_enable}, 16'd1);
    div_clock = 1'b0;
    wait_cycles(1);
    check_output("wrap_zero", step_count, 16'h0000);
    div_clock = 1'b1;
    wait_cycles(1);
    div_clock = 1'b0;
    wait_cycles(1);
    check_output("post_wrap_count", step_count, 16'h0001);

    // Asynchronous reset while a pulse is high
    div_clock = 1'b1;
    wait_cycles(1);
    check_output("live_pulse", {15'd0, cpu_enable}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_enable", {15'd0, cpu_enable}, 16'd0);
    check_output("async_reset_count", step_count, 16'd0);
    check_output("async_reset_state", {14'd0, state_led}, 16'd0);
    div_clock = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

CPU step-enable controller that sits directly downstream of the clock divider. It turns the divider's slow square wave, or a debounced manual push-button, into single-cycle `cpu_enable` pulses in the `clock_in` domain. The processor core advances one step per pulse. The block supports free-run, single-step and halt-on-CPU-request operation, and counts issued steps for display.

## Interface
- `DEBOUNCE`, default 20'd500000: cycles `step_button` must be stable before it is accepted; ≥2.
- `DB_WIDTH`, default 20: width of the debounce counter.
- `clock_in`, in, 1: FPGA clock; all logic on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `div_clock`, in, 1: divided clock from the divider. It is a register output in the `clock_in` domain, so it needs no synchronizer.
- `step_button`, in, 1: raw push-button, active-high, asynchronous, bouncy.
- `run_switch`, in, 1: raw slide switch, asynchronous. 1 = free-run, 0 = manual step.
- `halt`, in, 1: CPU halt request, synchronous, level.
- `cpu_enable`, out, 1: one-`clock_in`-cycle step pulse to the CPU.
- `state_led`, out, 2: current state. 00 STOP, 01 RUN, 10 HALTED.
- `step_count`, out, 16: number of `cpu_enable` pulses issued.

## Operation
- **Synchronizers**
  - `step_button` and `run_switch` each pass through 2-flop synchronizers (`*_s1`, `*_s2`).
  - `div_clock` is registered once into `div_d`.
  - `div_rise` = `div_clock & ~div_d`.
- **Debounce (`step_button` only)**
  - If `btn_s2 != btn_stable`: the counter increments. When the counter is at `DEBOUNCE-1`, `btn_stable <= btn_s2` and the counter clears.
  - If `btn_s2 == btn_stable`: the counter clears.
  - `step_req` = `btn_stable & ~btn_stable_d`. It fires once per press, and never on release.
- **FSM** (registered; reset state STOP)
  - STOP:
    - `halt` → HALTED, no pulse.
    - else `run_sync` → RUN, no pulse.
    - else `step_req` → pulse, stay in STOP.
  - RUN:
    - `halt` → HALTED. No pulse, even if `div_rise` is in the same cycle.
    - else `!run_sync` → STOP, no pulse.
    - else `div_rise` → pulse.
  - HALTED:
    - no pulses.
    - `!halt && !run_sync` → STOP. The operator must switch to manual before resuming.
    - `step_req` is ignored.
- **Pulse**: `cpu_enable` is a registered output, high for exactly one cycle per pulse decision.
- **Counter**: `step_count` increments on every cycle that `cpu_enable` is high, modulo 2^16 (0xFFFF → 0x0000).
- **Gaps**: two `cpu_enable` pulses are never back-to-back unless they come from two distinct `div_rise` or `step_req` events.

## Timing
- **Reset values**: `cpu_enable`=0, `state_led`=00, `step_count`=0. All synchronizers, `div_d`, the debounce counter and `btn_stable` also reset to 0.
- **Reset behaviour**:
  - Reset takes effect immediately, without waiting for a clock edge. A pulse in flight is cut.
  - After `reset_n` rises, the first edge operates normally.
- **RUN latency**: `cpu_enable` is high during the cycle after the first edge that samples `div_clock`=1. That is 1 cycle after the edge, with one pulse per `div_clock` period.
- **Step latency**: for a clean press first sampled at edge e0, `cpu_enable` is high after edge e0+`DEBOUNCE`+2, for one cycle.
- **Bounce rejection**: a bounce shorter than `DEBOUNCE` cycles after synchronization restarts the count and produces no pulse.
- **Run-switch latency**: a `run_switch` change reaches the FSM 2 cycles after it is sampled.
- **Halt latency**: `halt` takes effect at the next edge. No pulse is emitted in the cycle after `halt` is sampled high.
- **Simultaneous events**:
  - In STOP, `halt` beats `run_sync`, which beats `step_req`.
  - In RUN, `halt` beats `!run_sync`, which beats `div_rise`.

## Test plan
- **Reset**: hold `reset_n`=0 with `div_clock` toggling and `run_switch`=1 → `cpu_enable`=0, `state_led`=00, `step_count`=0. Release → `state_led`=01 within 3 cycles.
- **Free-run**: `DEBOUNCE`=4, `run_switch`=1, `div_clock` period 10 cycles for 100 cycles → 10 single-cycle pulses, each 1 cycle after a `div_clock` rise; `step_count`=10.
- **Single step**: `DEBOUNCE`=4, `run_switch`=0; press `step_button` clean for 20 cycles → exactly one pulse, at edge e0+6. Bounce 1-0-1 at 2-cycle intervals, then stable → still exactly one pulse. Releasing gives no pulse.
- **Halt**: in RUN, assert `halt` in the same cycle as a `div_rise` → no pulse, `state_led`=10. Deassert `halt` with `run_switch`=1 → stays HALTED. Set `run_switch`=0 → STOP after 3 cycles.
- **Wrap**: force or preload 0xFFFE issued pulses, then issue 2 pulses → `step_count`=0x0000.
- **Reset mid-operation**: assert `reset_n`=0 mid-cycle while `cpu_enable`=1 → `cpu_enable` drops without waiting for an edge; `step_count`=0.
